// File: rtl/mem_store_align.sv
// rtl/mem_store_align.sv - store-path byte-lane aligner issuing one or two word-aligned write beats
// Optional feature macro: MEM_STORE_MISALIGN_EN (split word-crossing stores into two beats)
module mem_store_align #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic [3:0]        mem_be,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

`ifdef MEM_STORE_MISALIGN_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1} state_t;
`endif

    state_t state, state_next;

    logic             legal_f3;
    logic [3:0]       mask;
    logic [1:0]       sh;
    logic [7:0]       be8;
    logic [WIDTH-1:0] data_m;
    logic             crossing;
    logic             req_ok;
    logic             load_req;
    logic             end_beat;
    logic             done_next;
    logic             err_next;

`ifdef MEM_STORE_MISALIGN_EN
    logic [2*WIDTH-1:0] d64;
    logic [WIDTH-1:0]   hi_wdata;
    logic [3:0]         hi_be;
    logic               load_hi;
`else
    logic [WIDTH-1:0]   d32;
`endif

    assign sh        = req_addr[1:0];
    assign req_ready = (state == IDLE);
    assign mem_valid = (state != IDLE);

    // Decode the request: lane mask, right-justified data trimmed to the access size, lane shift
    always_comb begin
        legal_f3 = 1'b1;
        mask     = 4'b0000;
        data_m   = req_data;
        case (req_funct3)
            F3_SB: begin
                mask   = 4'b0001;
                data_m = {{(WIDTH-8){1'b0}}, req_data[7:0]};
            end
            F3_SH: begin
                mask   = 4'b0011;
                data_m = {{(WIDTH-16){1'b0}}, req_data[15:0]};
            end
            F3_SW: begin
                mask   = 4'b1111;
                data_m = req_data;
            end
            default: legal_f3 = 1'b0;
        endcase
    end

    assign be8      = {4'b0000, mask} << sh;
    assign crossing = |be8[7:4];

`ifdef MEM_STORE_MISALIGN_EN
    assign d64    = {{WIDTH{1'b0}}, data_m} << {sh, 3'b000};
    assign req_ok = legal_f3;
`else
    assign d32    = data_m << {sh, 3'b000};
    assign req_ok = legal_f3 && !crossing;
`endif

    // State register; reset drops mem_valid immediately and discards any in-flight store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the datapath load/clear strobes
    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        end_beat   = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
`ifdef MEM_STORE_MISALIGN_EN
        load_hi    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_ok) begin
                        load_req   = 1'b1;
                        state_next = BEAT0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            BEAT0: begin
                if (mem_ready) begin
`ifdef MEM_STORE_MISALIGN_EN
                    if (hi_be != 4'b0000) begin
                        load_hi    = 1'b1;
                        state_next = BEAT1;
                    end else begin
                        end_beat   = 1'b1;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
`else
                    end_beat   = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
`endif
                end
            end
`ifdef MEM_STORE_MISALIGN_EN
            BEAT1: begin
                if (mem_ready) begin
                    end_beat   = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Beat registers: load on accept, advance to the upper word on split, clear enables when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef MEM_STORE_MISALIGN_EN
            hi_wdata  <= '0;
            hi_be     <= 4'b0000;
`endif
        end else begin
            done <= done_next;
            err  <= err_next;
            if (load_req) begin
                mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                mem_be   <= be8[3:0];
`ifdef MEM_STORE_MISALIGN_EN
                mem_wdata <= d64[WIDTH-1:0];
                hi_wdata  <= d64[2*WIDTH-1:WIDTH];
                hi_be     <= be8[7:4];
            end else if (load_hi) begin
                mem_addr  <= mem_addr + ADDR_W'(4);
                mem_wdata <= hi_wdata;
                mem_be    <= hi_be;
`else
                mem_wdata <= d32;
`endif
            end else if (end_beat) begin
                mem_be <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_mem_store_align.sv
// tb/tb_mem_store_align.sv - directed and random store stimulus against a byte-level model
module tb_mem_store_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

`ifdef MEM_STORE_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    int          nb;
    logic [31:0] eaddr [2];
    logic [31:0] edata [2];
    logic [3:0]  ebe   [2];

    mem_store_align #(.WIDTH(32), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte-by-byte model: each stored byte lands at address a+i, grouped by the word it falls in
    task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int size;
        int off;
        nb = 0;
        for (int k = 0; k < 2; k++) begin
            edata[k] = 32'h0;
            ebe[k]   = 4'h0;
        end
        eaddr[0] = a & 32'hFFFF_FFFC;
        eaddr[1] = eaddr[0] + 32'd4;
        if (f3 > 3'd2) return;
        size = 1 << f3;
        off  = int'(a[1:0]);
        if (off + size > 4 && !MIS) return;
        nb = (off + size > 4) ? 2 : 1;
        for (int i = 0; i < size; i++) begin
            int k;
            int lane;
            k    = (off + i) / 4;
            lane = (off + i) % 4;
            edata[k][lane*8 +: 8] = d[i*8 +: 8];
            ebe[k][lane]          = 1'b1;
        end
    endtask

    task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_addr   = a;
        req_data   = d;
        check("req_ready_at_accept", {63'h0, req_ready}, 64'h1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Called at the negedge of cycle N+1 after acceptance; walks the expected beats
    task automatic expect_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                input int stall);
        model(f3, a, d);
        if (nb == 0) begin
            check("err_pulse", {63'h0, err}, 64'h1);
            check("no_beat", {63'h0, mem_valid}, 64'h0);
            check("ready_after_err", {63'h0, req_ready}, 64'h1);
            @(negedge clk);
            check("err_clear", {63'h0, err}, 64'h0);
            check("no_beat_later", {63'h0, mem_valid}, 64'h0);
            return;
        end
        check("no_err", {63'h0, err}, 64'h0);
        for (int k = 0; k < nb; k++) begin
            for (int s = 0; s <= stall; s++) begin
                mem_ready = (s == stall);
                check("beat_valid", {63'h0, mem_valid}, 64'h1);
                check("beat_addr", {32'h0, mem_addr}, {32'h0, eaddr[k]});
                check("beat_wdata", {32'h0, mem_wdata}, {32'h0, edata[k]});
                check("beat_be", {60'h0, mem_be}, {60'h0, ebe[k]});
                check("beat_no_done", {63'h0, done}, 64'h0);
                @(negedge clk);
            end
            mem_ready = 1'b0;
        end
        check("done_pulse", {63'h0, done}, 64'h1);
        check("idle_valid", {63'h0, mem_valid}, 64'h0);
        check("idle_ready", {63'h0, req_ready}, 64'h1);
        check("idle_be", {60'h0, mem_be}, 64'h0);
        check("idle_addr_hold", {32'h0, mem_addr}, {32'h0, eaddr[nb-1]});
        @(negedge clk);
        check("done_clear", {63'h0, done}, 64'h0);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         input int stall);
        drive_req(f3, a, d);
        expect_store(f3, a, d, stall);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_data   = 32'h0;
        mem_ready  = 1'b0;
        #1;
        check("rst_req_ready", {63'h0, req_ready}, 64'h1);
        check("rst_mem_valid", {63'h0, mem_valid}, 64'h0);
        check("rst_mem_be", {60'h0, mem_be}, 64'h0);
        check("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
        check("rst_mem_wdata", {32'h0, mem_wdata}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_err", {63'h0, err}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // mem_ready must be ignored while idle
        mem_ready = 1'b1;
        @(negedge clk);
        check("idle_ready_ignored", {63'h0, mem_valid}, 64'h0);
        mem_ready = 1'b0;

        store(3'b000, 32'h0000_1003, 32'hAABB_CCDD, 0);
        store(3'b001, 32'h0000_2002, 32'h0000_1234, 3);
        store(3'b010, 32'h0000_3001, 32'h1122_3344, 0);
        store(3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D, 1);
        store(3'b001, 32'h0000_2001, 32'h0000_BEEF, 0);
        store(3'b001, 32'h0000_2003, 32'h0000_BEEF, 0);

        // Illegal funct3 followed by a back-to-back SW accepted in the err cycle
        drive_req(3'b011, 32'h0000_4000, 32'h1234_5678);
        check("ill_err", {63'h0, err}, 64'h1);
        check("ill_no_beat", {63'h0, mem_valid}, 64'h0);
        check("ill_ready", {63'h0, req_ready}, 64'h1);
        drive_req(3'b010, 32'h0000_4000, 32'h5566_7788);
        expect_store(3'b010, 32'h0000_4000, 32'h5566_7788, 0);

        // Reset in the last beat of an in-flight store
`ifdef MEM_STORE_MISALIGN_EN
        drive_req(3'b010, 32'h0000_3001, 32'h1122_3344);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("beat1_addr", {32'h0, mem_addr}, 64'h3004);
`else
        drive_req(3'b010, 32'h0000_5000, 32'h1122_3344);
`endif
        check("inflight_valid", {63'h0, mem_valid}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {63'h0, mem_valid}, 64'h0);
        check("arst_be", {60'h0, mem_be}, 64'h0);
        check("arst_addr", {32'h0, mem_addr}, 64'h0);
        check("arst_wdata", {32'h0, mem_wdata}, 64'h0);
        check("arst_ready", {63'h0, req_ready}, 64'h1);
        @(negedge clk);
        check("arst_no_done", {63'h0, done}, 64'h0);
        check("arst_no_err", {63'h0, err}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_no_done", {63'h0, done}, 64'h0);
        store(3'b000, 32'h0000_6002, 32'h0000_00A5, 1);

        for (int n = 0; n < 60; n++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] d;
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = $urandom;
            d  = $urandom;
            store(f3, a, d, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_store_align.md
# mem_store_align

Store-path counterpart to the load extender in the single-cycle core's memory stage. Accepts one store request per handshake (SB/SH/SW selected by funct3), aligns the data to word byte lanes and generates byte enables. Issues one or two word-aligned write beats to the data-memory port over a valid/ready handshake. Misaligned stores that cross a word boundary are split into two beats when the misaligned-store feature is compiled in.

## Interface
- WIDTH, 32, data width; only 32 is supported.
- ADDR_W, 32, byte-address width.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_funct3  in  3  000=SB, 001=SH, 010=SW; any other value is illegal.
- req_addr  in  ADDR_W  byte address.
- req_data  in  WIDTH  store data, right-justified.
- mem_valid  out  1  write beat present.
- mem_ready  in  1  memory accepts the beat.
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0]=0.
- mem_wdata  out  WIDTH  lane-aligned write data.
- mem_be  out  4  byte enables; bit i enables byte lane i.
- done  out  1  one-cycle pulse after the final beat of a store is accepted.
- err  out  1  one-cycle pulse after an illegal or rejected request.

## Operation
- States are IDLE, BEAT0 and BEAT1. `req_ready` is high only when the state is IDLE.
- Request handshake (IDLE, `req_valid`=1): latch funct3, address and data. Compute:
  - base mask: 0001 for SB, 0011 for SH, 1111 for SW.
  - `sh` = `req_addr[1:0]`.
  - 8-bit enable `be8` = mask << sh.
  - 64-bit lanes `d64` = zero-extended data << (8*sh).
- Data not covered by the mask is don't-care, but it must not enter enabled lanes. SB and SH data are masked to 8 or 16 bits before shifting.
- Illegal funct3 (011, 1xx): stay in IDLE, pulse `err` the next cycle, issue no beat.
- Legal request: go to BEAT0.
- BEAT0 drives:
  - `mem_addr` = {`req_addr`[ADDR_W-1:2], 2'b00}
  - `mem_wdata` = `d64[31:0]`
  - `mem_be` = `be8[3:0]`
- On the BEAT0 handshake:
  - if `be8[7:4]` != 0, go to BEAT1;
  - otherwise go to IDLE and pulse `done`.
- BEAT1 drives `mem_addr` = BEAT0 address + 4, modulo 2^ADDR_W. `mem_wdata` = `d64[63:32]`, `mem_be` = `be8[7:4]`. On its handshake, go to IDLE and pulse `done`.
- `mem_valid` is high exactly in BEAT0 and BEAT1. `mem_addr`, `mem_wdata` and `mem_be` hold stable while `mem_valid`=1 and `mem_ready`=0.
- Outside beats: `mem_be`=0; `mem_addr` and `mem_wdata` hold their last values.

## Timing
- Reset values:
  - state IDLE, so `req_ready`=1.
  - `mem_valid`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
  - `done`=0, `err`=0.
- Request accepted in cycle N: `mem_valid` rises in N+1.
- Final beat handshake in cycle M: `done`=1 and `req_ready`=1 in M+1.
- Aligned stores sustain one store per 2 cycles when `mem_ready`=1. Split stores take 3 cycles.
- `err` for a rejected request is high in N+1 only. `req_ready` stays high, so a new request may be accepted in N+1.
- Reset asserted mid-transfer: `mem_valid` drops asynchronously. The in-flight store is discarded, with no `done` and no `err`.
- `mem_ready` is ignored while `mem_valid`=0.

## Configuration
- `MEM_STORE_MISALIGN_EN` defined: stores crossing a word boundary are split as above. These are SH with sh=3 and SW with sh≠0.
- Undefined: such requests are rejected like an illegal funct3, with an `err` pulse and no beat. The BEAT1 state is not built. Non-crossing misaligned SH (sh=1) still produces a single beat.

## Test plan
- SB, addr 0x1003, data 0xAABBCCDD -> one beat: addr 0x1000, wdata 0xDD000000, be 1000; `done` one cycle later.
- SH, addr 0x2002, data 0x00001234, `mem_ready` held low for 3 cycles -> one beat: addr 0x2000, wdata 0x12340000, be 1100, stable for all 4 valid cycles.
- SW, addr 0x3001, data 0x11223344, macro defined -> BEAT0: 0x3000 / 0x22334400 / be 1110. BEAT1: 0x3004 / 0x00000011 / be 0001. Then `done`. With the macro undefined -> `err` pulse, `mem_valid` never rises.
- SW, addr 0xFFFFFFFE, macro defined -> BEAT0 addr 0xFFFFFFFC, be 1100. BEAT1 addr 0x00000000, be 0011.
- funct3 = 011 -> `err`=1 for one cycle, no beat, `req_ready` stays 1. A back-to-back SW to 0x4000 is then accepted with one beat and be 1111.
- `rst_n` pulsed low during BEAT1 -> `mem_valid`=0 immediately, all outputs at reset values, no `done`. A following request behaves normally.
